fetch_unit_l1: RTL

- In-order, single-issue fetch unit: the producer end of the F->D handshake.
- Generates sequential PCs, issues instruction-memory requests, buffers in-order responses, and presents {inst, pc, seq_num} to decode with val/rdy.
- Allocates sequence numbers and reclaims them on commit notification.

---
 rtl/fetch_unit_l1_pkg.sv | 17 +
 rtl/fetch_unit_l1_if.sv | 32 +++
 rtl/fetch_unit_l1_fetch_buffer.sv | 63 ++++++
 rtl/fetch_unit_l1.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/fetch_unit_l1_pkg.sv
// Shared types for the fetch unit: the request tag carried in the memory opaque field
// and the {inst, pc} entry presented to decode.
package fetch_unit_l1_pkg;

  localparam int unsigned XLen = 32;
  localparam logic [XLen-1:0] PcStep = 32'd4;

  typedef struct packed {
    logic epoch;
  } fetch_tag_t;

  typedef struct packed {
    logic [XLen-1:0] inst;
    logic [XLen-1:0] pc;
  } buf_entry_t;

endpackage

// File: rtl/fetch_unit_l1_if.sv
// Memory request/response and fetch-to-decode handshake bundle.
// master: the fetch unit; slave: memory and decode.
interface fetch_unit_l1_if #(
  parameter int unsigned p_opaque_bits  = 8,
  parameter int unsigned p_seq_num_bits = 5
);
  logic                      mem_req_val;
  logic                      mem_req_rdy;
  logic [31:0]               mem_req_addr;
  logic [p_opaque_bits-1:0]  mem_req_opaque;
  logic                      mem_resp_val;
  logic                      mem_resp_rdy;
  logic [31:0]               mem_resp_data;
  logic [p_opaque_bits-1:0]  mem_resp_opaque;
  logic                      d_val;
  logic                      d_rdy;
  logic [31:0]               d_inst;
  logic [31:0]               d_pc;
  logic [p_seq_num_bits-1:0] d_seq_num;

  modport master (
    output mem_req_val, mem_req_addr, mem_req_opaque, mem_resp_rdy,
    output d_val, d_inst, d_pc, d_seq_num,
    input  mem_req_rdy, mem_resp_val, mem_resp_data, mem_resp_opaque, d_rdy
  );

  modport slave (
    input  mem_req_val, mem_req_addr, mem_req_opaque, mem_resp_rdy,
    input  d_val, d_inst, d_pc, d_seq_num,
    output mem_req_rdy, mem_resp_val, mem_resp_data, mem_resp_opaque, d_rdy
  );
endinterface

// File: rtl/fetch_unit_l1_fetch_buffer.sv
// Small synchronous FIFO with flush; push is accepted when full if a pop happens
// in the same cycle. Depth must be a power of two >= 2.
module fetch_unit_l1_fetch_buffer #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  always_comb begin
    empty_o = (cnt_q == '0);
    full_o  = (cnt_q == CntW'(Depth));
    rdata_o = mem_q[rptr_q];
    pop_ok  = pop_i & ~empty_o;
    push_ok = push_i & (~full_o | pop_ok);
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (push_ok) begin
      mem_d[wptr_q] = wdata_i;
      wptr_d        = wptr_q + PtrW'(1);
    end
    if (pop_ok) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    cnt_d = cnt_q + CntW'(push_ok) - CntW'(pop_ok);
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_unit_l1.sv
// In-order single-issue fetch unit: sequential PC generation, bounded outstanding fetches,
// in-order response buffering and sequence-number allocation. Optional: FETCH_REDIRECT_EN.
module fetch_unit_l1
  import fetch_unit_l1_pkg::*;
#(
  parameter logic [31:0] p_rst_addr      = 32'h200,
  parameter int unsigned p_num_in_flight = 2,
  parameter int unsigned p_seq_num_bits  = 5,
  parameter int unsigned p_opaque_bits   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  fetch_unit_l1_if.master        bus,
  input  logic                   commit_val
`ifdef FETCH_REDIRECT_EN
  ,
  input  logic                   redirect_val,
  input  logic [31:0]            redirect_target
`endif
);
  localparam int unsigned CntW = $clog2(p_num_in_flight + 1);
  localparam int unsigned SeqW = p_seq_num_bits + 1;

  logic [31:0]     pc_q, pc_d;
  logic [CntW-1:0] inflight_q, inflight_d;
  // One extra bit so alloc - free spans 0..2^p_seq_num_bits.
  logic [SeqW-1:0] alloc_q, alloc_d, free_q, free_d, live;
  fetch_tag_t      tag_q, tag_d;
  buf_entry_t      head;
  logic            req_fire, resp_keep, d_fire, flush;
  logic            inst_empty, inst_full, pc_empty, pc_full;
  logic [31:0]     inst_head, pc_head;
`ifdef FETCH_REDIRECT_EN
  logic [CntW-1:0] outst_q, outst_d;
`endif

  always_comb begin
    bus.mem_req_val    = ~rst & (inflight_q < CntW'(p_num_in_flight));
    bus.mem_req_addr   = pc_q;
    bus.mem_req_opaque = p_opaque_bits'(tag_q.epoch);
    bus.mem_resp_rdy   = 1'b1;
    req_fire           = bus.mem_req_val & bus.mem_req_rdy;
    live               = alloc_q - free_q;
`ifdef FETCH_REDIRECT_EN
    resp_keep = bus.mem_resp_val & (bus.mem_resp_opaque[0] == tag_q.epoch);
    flush     = redirect_val;
`else
    resp_keep = bus.mem_resp_val;
    flush     = 1'b0;
`endif
    bus.d_val     = ~inst_empty & ~live[SeqW-1] & ~flush;
    d_fire        = bus.d_val & bus.d_rdy;
    head          = '{inst: inst_head, pc: pc_head};
    bus.d_inst    = head.inst;
    bus.d_pc      = head.pc;
    bus.d_seq_num = alloc_q[p_seq_num_bits-1:0];
  end

  always_comb begin
    pc_d       = req_fire ? pc_q + PcStep : pc_q;
    inflight_d = inflight_q + CntW'(req_fire) - CntW'(d_fire);
    alloc_d    = alloc_q + SeqW'(d_fire);
    free_d     = free_q + SeqW'(commit_val);
    tag_d      = tag_q;
`ifdef FETCH_REDIRECT_EN
    outst_d = outst_q + CntW'(req_fire) - CntW'(bus.mem_resp_val);
    // Stale responses must also release their in-flight slot or fetch would starve.
    if (bus.mem_resp_val & ~resp_keep) begin
      inflight_d = inflight_d - CntW'(1);
    end
    if (redirect_val) begin
      pc_d        = redirect_target;
      tag_d.epoch = ~tag_q.epoch;
      inflight_d  = outst_d;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= p_rst_addr;
      inflight_q <= '0;
      alloc_q    <= '0;
      free_q     <= '0;
      tag_q      <= '0;
`ifdef FETCH_REDIRECT_EN
      outst_q    <= '0;
`endif
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      alloc_q    <= alloc_d;
      free_q     <= free_d;
      tag_q      <= tag_d;
`ifdef FETCH_REDIRECT_EN
      outst_q    <= outst_d;
`endif
    end
  end

  fetch_unit_l1_fetch_buffer #(
    .Depth (p_num_in_flight),
    .Width (32)
  ) u_inst_buf (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (resp_keep),
    .wdata_i (bus.mem_resp_data),
    .pop_i   (d_fire),
    .rdata_o (inst_head),
    .empty_o (inst_empty),
    .full_o  (inst_full)
  );

  // PCs are queued at request time; in-order memory keeps them aligned with instructions.
  fetch_unit_l1_fetch_buffer #(
    .Depth (p_num_in_flight),
    .Width (32)
  ) u_pc_buf (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (req_fire),
    .wdata_i (pc_q),
    .pop_i   (d_fire),
    .rdata_o (pc_head),
    .empty_o (pc_empty),
    .full_o  (pc_full)
  );

  a_commit_live: assert property (@(posedge clk) disable iff (rst) commit_val |-> live != '0)
    else $error("commit_val with no live sequence numbers");
  a_inst_space: assert property (@(posedge clk) disable iff (rst) resp_keep |-> !inst_full || d_fire)
    else $error("response arrived with instruction buffer full");
  a_pc_space: assert property (@(posedge clk) disable iff (rst) req_fire |-> !pc_full || d_fire)
    else $error("request issued with pc buffer full");
  a_pc_align: assert property (@(posedge clk) disable iff (rst) bus.d_val |-> !pc_empty)
    else $error("instruction present without matching pc");

endmodule
